rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port (rd / write_data / reg_write) between two writeback requesters: req0 (ALU) and req1 (load/store unit).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs.
- Per-register busy scoreboard consulted by issue/decode for RAW hazards.
- Sits between the execute/memory stages and register_file.

Parameters:
- XLEN, 32, data width of write_data.
- REG_ADDR_W, 5, width of register index.
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W).
- STAT_W, 16, width of optional statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  input  1  ALU writeback request.
- req0_rd  input  REG_ADDR_W  ALU destination register.
- req0_data  input  XLEN  ALU result.
- req0_ready  output  1  ALU request accepted this cycle.
- req1_valid  input  1  LSU writeback request.
- req1_rd  input  REG_ADDR_W  LSU destination register.
- req1_data  input  XLEN  load data.
- req1_ready  output  1  LSU request accepted this cycle.
- sb_set_valid  input  1  issue stage marks a destination as pending.
- sb_set_rd  input  REG_ADDR_W  register to mark busy.
- rf_rd  output  REG_ADDR_W  to register_file rd.
- rf_write_data  output  XLEN  to register_file write_data.
- rf_reg_write  output  1  to register_file reg_write.
- busy  output  NUM_REGS  scoreboard; bit i = write to xi pending.

Behaviour:
- Reset (reset=0, async): rf_reg_write=0, rf_rd=0, rf_write_data=0, busy=0, RR pointer=req0 preferred. Asynchronous assert; clear is sampled on clk.
- Handshake: reqN_ready is combinational from the valids and the RR pointer. Transfer when valid&&ready. At most one ready per cycle. A ready is never asserted without its valid.
- Requester rule: once valid is raised, rd/data are held stable until accepted.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: the requester not granted last is granted; the other waits.
  - Pointer updates only on a transfer.
- Latency: a request accepted in cycle N appears on rf_rd/rf_write_data with rf_reg_write=1 in cycle N+1, for exactly one cycle.
- Throughput: one write per cycle. rf_reg_write=0 in cycles with no transfer. rf_rd/rf_write_data hold their last values.
- x0: a request with rd=0 is accepted normally, but rf_reg_write stays 0 in cycle N+1.
- Scoreboard:
  - Busy[sb_set_rd] sets on the clock edge when sb_set_valid=1.
  - Busy[rf_rd] clears on the edge ending the cycle where rf_reg_write=1.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
  - Setting or clearing different registers in the same cycle: both take effect.
  - busy[0] is constant 0; sb_set with rd=0 is ignored.
- Reset mid-operation: a pending accepted write is dropped (rf_reg_write=0), all busy bits clear, and the RR pointer returns to req0.
- No internal queue: a blocked requester simply stalls; there is no starvation, since the loser wins the next conflict.

Optional Feature:
- Macro RF_ARB_STATS_EN.
- Defined: adds outputs stat_writes (STAT_W; counts cycles with rf_reg_write=1) and stat_conflicts (STAT_W; counts cycles with req0_valid&&req1_valid).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rf_pkg: XLEN, REG_ADDR_W, NUM_REGS constants; requester index constants REQ_ALU=0, REQ_LSU=1; typedef reg_idx_t.
- One sub-module: rr_arbiter2. It is a 2-way round-robin grant: inputs req[1:0] and advance, output grant[1:0] one-hot or zero, with an internal pointer flop on the same clk/reset.
- The scoreboard and output registers stay in rf_write_arbiter.

Test Plan:
- Single write: req0 valid, rd=1, data=100 at cycle N. Expect req0_ready=1 in N. Next cycle rf_reg_write=1, rf_rd=1, rf_write_data=100. Register_file then reads x1=100.
- Conflict: both valid (req0 rd=2/200, req1 rd=3/300) for 2 cycles after reset.
  - req0 is granted first; then req1.
  - rf writes x2=200 then x3=300 on consecutive cycles.
  - A third conflict grants req0.
- x0 suppression: req1 valid, rd=0, data=300. Expect req1_ready=1, rf_reg_write stays 0, and reading x0 returns 0.
- Scoreboard: sb_set rd=5, then busy[5]=1.
  - Write rd=5 accepted: busy[5] clears one cycle after rf_reg_write.
  - Same-cycle sb_set rd=5 with commit rd=5 leaves busy[5]=1.
- Async reset mid-operation: drop reset to 0 between edges while a write is pending. Expect rf_reg_write=0 and busy=0 immediately. After release, the next conflict grants req0.
- Stats (RF_ARB_STATS_EN): run 3 writes with 2 conflict cycles. Expect stat_writes=3 and stat_conflicts=2. Force 2**STAT_W+5 conflicts; expect stat_conflicts saturates at 16'hFFFF.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file write arbiter slice.
//   XLEN        : data width of a register write
//   REG_ADDR_W  : register index width
//   NUM_REGS    : number of architectural registers
//   STAT_W      : width of the optional statistics counters (RF_ARB_STATS_EN)
//   REQ_ALU/LSU : requester indices into the grant/request vectors
// -----------------------------------------------------------------------------
package rf_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int STAT_W     = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       data_t;
    typedef logic [STAT_W-1:0]     stat_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic stat_t sat_inc(input stat_t v);
        return (&v) ? v : stat_t'(v + 1'b1);
    endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the two writeback request channels, the issue-stage scoreboard set
// port, the register-file write port and the busy vector.
//   master : requester / issue side (drives valids, rd, data, sb_set)
//   slave  : the arbiter (drives readies, rf_* write port, busy)
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                req0_valid;
    reg_idx_t            req0_rd;
    data_t               req0_data;
    logic                req0_ready;

    logic                req1_valid;
    reg_idx_t            req1_rd;
    data_t               req1_data;
    logic                req1_ready;

    logic                sb_set_valid;
    reg_idx_t            sb_set_rd;

    reg_idx_t            rf_rd;
    data_t               rf_write_data;
    logic                rf_reg_write;
    logic [NUM_REGS-1:0] busy;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output sb_set_valid, sb_set_rd,
        input  rf_rd, rf_write_data, rf_reg_write, busy
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  sb_set_valid, sb_set_rd,
        output rf_rd, rf_write_data, rf_reg_write, busy
    );
endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset (pointer returns to requester 0)
//   req     : request vector
//   advance : a transfer happened this cycle; move the pointer past the winner
//   grant   : one-hot or zero, never set without the matching req bit
// -----------------------------------------------------------------------------
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    // Index of the requester that wins the next conflict.
    logic pref_q, pref_d;

    always_comb begin
        grant = req;
        if (&req) begin
            grant = pref_q ? 2'b10 : 2'b01;
        end

        pref_d = pref_q;
        if (advance) begin
            if (grant[REQ_ALU]) begin
                pref_d = 1'b1;
            end else if (grant[REQ_LSU]) begin
                pref_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pref_q <= 1'b0;
        end else begin
            pref_q <= pref_d;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the ALU (req0) and the
// LSU (req1) with round-robin arbitration, registers the write port, and keeps
// a per-register busy scoreboard for RAW hazard detection.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   bus (slave)    : request channels, sb_set, rf_* write port, busy
//   stat_writes    : cycles with rf_reg_write=1, saturating  (RF_ARB_STATS_EN)
//   stat_conflicts : cycles with both requests valid, saturating (RF_ARB_STATS_EN)
// Optional feature macro: RF_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    rf_write_arbiter_if.slave   bus
`ifdef RF_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_writes,
    output logic [STAT_W-1:0]   stat_conflicts
`endif
);
    logic [1:0]          req;
    logic [1:0]          grant;
    logic                transfer;
    reg_idx_t            sel_rd;
    data_t               sel_data;

    reg_idx_t            rf_rd_q, rf_rd_d;
    data_t               rf_write_data_q, rf_write_data_d;
    logic                rf_reg_write_q, rf_reg_write_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    assign req[REQ_ALU] = bus.req0_valid;
    assign req[REQ_LSU] = bus.req1_valid;
    assign transfer     = |grant;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (transfer),
        .grant   (grant)
    );

    assign bus.req0_ready    = grant[REQ_ALU];
    assign bus.req1_ready    = grant[REQ_LSU];
    assign bus.rf_rd         = rf_rd_q;
    assign bus.rf_write_data = rf_write_data_q;
    assign bus.rf_reg_write  = rf_reg_write_q;
    assign bus.busy          = busy_q;

    always_comb begin
        sel_rd   = grant[REQ_LSU] ? bus.req1_rd   : bus.req0_rd;
        sel_data = grant[REQ_LSU] ? bus.req1_data : bus.req0_data;

        // Address/data hold between transfers; the strobe is a one-cycle pulse.
        rf_rd_d         = rf_rd_q;
        rf_write_data_d = rf_write_data_q;
        rf_reg_write_d  = 1'b0;
        if (transfer) begin
            rf_rd_d         = sel_rd;
            rf_write_data_d = sel_data;
            // x0 writes are consumed but never strobed into the file.
            rf_reg_write_d  = (sel_rd != '0);
        end

        // Clear before set so a same-register collision leaves the bit busy.
        busy_d = busy_q;
        if (rf_reg_write_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (bus.sb_set_valid) begin
            busy_d[bus.sb_set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_rd_q         <= '0;
            rf_write_data_q <= '0;
            rf_reg_write_q  <= 1'b0;
            busy_q          <= '0;
        end else begin
            rf_rd_q         <= rf_rd_d;
            rf_write_data_q <= rf_write_data_d;
            rf_reg_write_q  <= rf_reg_write_d;
            busy_q          <= busy_d;
        end
    end

`ifdef RF_ARB_STATS_EN
    stat_t stat_writes_q, stat_writes_d;
    stat_t stat_conflicts_q, stat_conflicts_d;

    always_comb begin
        stat_writes_d    = rf_reg_write_q ? sat_inc(stat_writes_q) : stat_writes_q;
        stat_conflicts_d = (&req) ? sat_inc(stat_conflicts_q) : stat_conflicts_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_writes_q    <= '0;
            stat_conflicts_q <= '0;
        end else begin
            stat_writes_q    <= stat_writes_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_writes    = stat_writes_q;
    assign stat_conflicts = stat_conflicts_q;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Scoreboard bench: each driven cycle pushes the expected DUT view of that
// cycle (readies, write port, busy vector, stats) computed by a behavioural
// model; a monitor pops and compares on every falling edge.
// Define RF_ARB_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;
    import rf_pkg::*;

    typedef struct {
        int                  cyc;
        bit                  r0;
        bit                  r1;
        bit                  we;
        reg_idx_t            rd;
        data_t               data;
        bit [NUM_REGS-1:0]   busy;
        int                  sw;
        int                  sc;
    } exp_t;

    localparam int STAT_MAX = (2 ** STAT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t exp_q[$];

    // Behavioural model state
    int       m_pref;          // requester that wins the next conflict
    bit       m_busy [NUM_REGS];
    bit       m_pend_we;
    reg_idx_t m_pend_rd;
    data_t    m_pend_data;
    int       m_sw;
    int       m_sc;

    rf_write_arbiter_if bus ();

`ifdef RF_ARB_STATS_EN
    logic [STAT_W-1:0] stat_writes;
    logic [STAT_W-1:0] stat_conflicts;
`endif

    rf_write_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_writes    (stat_writes),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pref      = 0;
        m_pend_we   = 1'b0;
        m_pend_rd   = '0;
        m_pend_data = '0;
        m_sw        = 0;
        m_sc        = 0;
        for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
    endtask

    // Drive one cycle of stimulus and push what the DUT must show in it.
    task automatic step(input bit v0, input reg_idx_t rd0, input data_t d0,
                        input bit v1, input reg_idx_t rd1, input data_t d1,
                        input bit sv, input reg_idx_t srd,
                        output bit g0, output bit g1);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req0_valid   = v0;
        bus.req0_rd      = rd0;
        bus.req0_data    = d0;
        bus.req1_valid   = v1;
        bus.req1_rd      = rd1;
        bus.req1_data    = d1;
        bus.sb_set_valid = sv;
        bus.sb_set_rd    = srd;

        if (v0 && v1) begin
            g0 = (m_pref == 0);
            g1 = !g0;
        end else begin
            g0 = v0;
            g1 = v1;
        end

        e.cyc  = cyc;
        e.r0   = g0;
        e.r1   = g1;
        e.we   = m_pend_we;
        e.rd   = m_pend_rd;
        e.data = m_pend_data;
        for (int i = 0; i < NUM_REGS; i++) e.busy[i] = m_busy[i];
        e.sw   = m_sw;
        e.sc   = m_sc;
        exp_q.push_back(e);

        // Advance the model to the next cycle
        if (m_pend_we) begin
            m_busy[m_pend_rd] = 1'b0;
            if (m_sw < STAT_MAX) m_sw++;
        end
        if (v0 && v1 && m_sc < STAT_MAX) m_sc++;
        if (sv && srd != 0) m_busy[srd] = 1'b1;
        if (g0) begin
            m_pend_we = (rd0 != 0); m_pend_rd = rd0; m_pend_data = d0; m_pref = 1;
        end else if (g1) begin
            m_pend_we = (rd1 != 0); m_pend_rd = rd1; m_pend_data = d1; m_pref = 0;
        end else begin
            m_pend_we = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, '0, a, b);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("stale_expectation", 64'(e.cyc), 64'(cyc));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("req0_ready", 64'(bus.req0_ready), 64'(e.r0));
                check("req1_ready", 64'(bus.req1_ready), 64'(e.r1));
                check("rf_reg_write", 64'(bus.rf_reg_write), 64'(e.we));
                if (e.we) begin
                    check("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
                    check("rf_write_data", 64'(bus.rf_write_data), 64'(e.data));
                end
                check("busy", 64'(bus.busy), 64'(e.busy));
`ifdef RF_ARB_STATS_EN
                check("stat_writes", 64'(stat_writes), 64'(e.sw));
                check("stat_conflicts", 64'(stat_conflicts), 64'(e.sc));
`endif
            end
        end
    end

    // Stimulus
    initial begin
        bit       g0, g1;
        bit       h0_v, h1_v, s_v;
        reg_idx_t h0_rd, h1_rd, s_rd;
        data_t    h0_d, h1_d;

        bus.req0_valid = 0; bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_rd = '0; bus.req1_data = '0;
        bus.sb_set_valid = 0; bus.sb_set_rd = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        check("reset_rf_rd", 64'(bus.rf_rd), 64'd0);
        check("reset_rf_write_data", 64'(bus.rf_write_data), 64'd0);
        check("reset_rf_reg_write", 64'(bus.rf_reg_write), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        #1 reset = 1'b1;

        // Single write
        step(1, 5'd1, 32'd100, 0, '0, '0, 0, '0, g0, g1);
        idle(1);
        // Conflicts: req0, then req1, then req0 again
        step(1, 5'd2, 32'd200, 1, 5'd3, 32'd300, 0, '0, g0, g1);
        step(1, 5'd2, 32'd200, 1, 5'd3, 32'd300, 0, '0, g0, g1);
        step(1, 5'd2, 32'd200, 1, 5'd3, 32'd300, 0, '0, g0, g1);
        idle(1);
        // x0 suppression
        step(0, '0, '0, 1, 5'd0, 32'd300, 0, '0, g0, g1);
        idle(1);
        // Scoreboard set / clear / same-cycle set-wins
        step(0, '0, '0, 0, '0, '0, 1, 5'd5, g0, g1);
        step(1, 5'd5, 32'h55, 0, '0, '0, 0, '0, g0, g1);
        step(0, '0, '0, 0, '0, '0, 1, 5'd5, g0, g1);   // commit rd5 + set rd5
        step(1, 5'd5, 32'h56, 0, '0, '0, 1, 5'd7, g0, g1);
        step(0, '0, '0, 0, '0, '0, 1, 5'd0, g0, g1);   // commit rd5, set x0 ignored
        idle(2);

        // Async reset while a write is pending
        step(0, '0, '0, 0, '0, '0, 1, 5'd9, g0, g1);
        step(1, 5'd9, 32'h99, 0, '0, '0, 0, '0, g0, g1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.sb_set_valid = 0;
        #1;
        check("async_reset_busy", 64'(bus.busy), 64'd0);
        check("async_reset_rf_reg_write", 64'(bus.rf_reg_write), 64'd0);
        @(negedge clk);
        check("reset_drop_rf_reg_write", 64'(bus.rf_reg_write), 64'd0);
        check("reset_drop_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, '0, g0, g1);
        step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, '0, g0, g1);
        step(1, 5'd12, 32'hC0, 0, '0, '0, 0, '0, g0, g1);
        idle(2);

        // Randomized traffic with hold-until-accepted requesters
        h0_v = 0; h1_v = 0;
        h0_rd = '0; h1_rd = '0; h0_d = '0; h1_d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!h0_v || g0) begin
                h0_v  = ($urandom_range(0, 99) < 60);
                h0_rd = reg_idx_t'($urandom_range(0, 7));
                h0_d  = $urandom;
            end
            if (!h1_v || g1) begin
                h1_v  = ($urandom_range(0, 99) < 60);
                h1_rd = reg_idx_t'($urandom_range(0, 7));
                h1_d  = $urandom;
            end
            s_v  = ($urandom_range(0, 99) < 50);
            s_rd = reg_idx_t'($urandom_range(0, 7));
            g0 = 0; g1 = 0;
            step(h0_v, h0_rd, h0_d, h1_v, h1_rd, h1_d, s_v, s_rd, g0, g1);
        end
        idle(2);

`ifdef RF_ARB_STATS_EN
        // Drive both counters into saturation
        for (int i = 0; i < (2 ** STAT_W) + 5; i++) begin
            step(1, 5'd4, data_t'(i), 1, 5'd6, data_t'(~i), 0, '0, g0, g1);
        end
        idle(2);
`endif

        @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
